// File: rtl/legv8_mc_control_if.sv
// Control bundle between the LEGv8 multi-cycle main controller (master) and
// the datapath it steers (slave): opcode and memory-ready in, enables and selects out.
interface legv8_mc_control_if;
    logic [10:0] instruction;
    logic        mem_ready;
    logic [1:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  instruction, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
               MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, illegal, state
    );

    modport slave (
        output instruction, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
               MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, illegal, state
    );
endinterface

// File: rtl/legv8_mc_control.sv
// LEGv8 multi-cycle main control FSM (Moore outputs, mem_ready-gated strobes).
// Define LEGV8_ILLEGAL_TRAP_EN to trap unrecognised opcodes in a HALT state.
module legv8_mc_control (
    input  logic                  clk,
    input  logic                  rst_n,
    legv8_mc_control_if.master    bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_CBZ    = 4'd8,
        S_JUMP   = 4'd9
`ifdef LEGV8_ILLEGAL_TRAP_EN
        , S_HALT = 4'd10
`endif
    } state_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    state_t state_q, state_d;

    logic       is_ldur, is_stur, is_rtype, is_cbz, is_b;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic       alu_src_a, pc_write, pc_write_cond, iord, mem_read;
    logic       mem_write, ir_write, mem_to_reg, reg_write, illegal;

    assign is_ldur  = (bus.instruction == OP_LDUR);
    assign is_stur  = (bus.instruction == OP_STUR);
    assign is_rtype = (bus.instruction == OP_ADD) || (bus.instruction == OP_SUB) ||
                      (bus.instruction == OP_AND) || (bus.instruction == OP_ORR);
    assign is_cbz   = (bus.instruction[10:3] == 8'b10110100);
    assign is_b     = (bus.instruction[10:5] == 6'b000101);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target (PC + offset<<2) is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                // Exact opcode matches are tested before the CBZ/B prefix matches.
                if (is_ldur || is_stur) begin
                    state_d = S_MEMADR;
                end else if (is_rtype) begin
                    state_d = S_EXEC;
                end else if (is_cbz) begin
                    state_d = S_CBZ;
                end else if (is_b) begin
                    state_d = S_JUMP;
                end else begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    illegal = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (is_ldur) begin
                    state_d = S_MEMRD;
                end else if (is_stur) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // The write strobe coincides with the ready cycle, so it fires once.
                iord      = 1'b1;
                mem_write = bus.mem_ready;
                state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_CBZ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
`ifdef LEGV8_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.ALUOp       = alu_op;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.PCSource    = pc_source;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.illegal     = illegal;
    assign bus.state       = state_q;
    // Architectural-state writes are held off for the whole reset assertion.
    assign bus.PCWrite     = pc_write      & rst_n;
    assign bus.PCWriteCond = pc_write_cond & rst_n;
    assign bus.IRWrite     = ir_write      & rst_n;
    assign bus.MemWrite    = mem_write     & rst_n;
    assign bus.RegWrite    = reg_write     & rst_n;
endmodule

// File: tb/tb_legv8_mc_control.sv
// Directed bench for legv8_mc_control: walks each instruction class cycle by
// cycle and compares state plus the full control word against hand-built constants.
module tb_legv8_mc_control;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    legv8_mc_control_if bus ();

    legv8_mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Control word: ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond,
    // IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, illegal
    logic [16:0] ctrl_word;
    assign ctrl_word = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                        bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                        bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegWrite,
                        bus.illegal};

    localparam logic [16:0] W_FETCH_RDY = 17'b00_0_01_00_1_0_0_1_0_1_0_0_0;
    localparam logic [16:0] W_FETCH_STL = 17'b00_0_01_00_0_0_0_1_0_0_0_0_0;
    localparam logic [16:0] W_DECODE    = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] W_DECODE_IL = 17'b00_0_11_00_0_0_0_0_0_0_0_0_1;
    localparam logic [16:0] W_MEMADR    = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] W_MEMRD     = 17'b00_0_00_00_0_0_1_1_0_0_0_0_0;
    localparam logic [16:0] W_MEMWB     = 17'b00_0_00_00_0_0_0_0_0_0_1_1_0;
    localparam logic [16:0] W_MEMWR_STL = 17'b00_0_00_00_0_0_1_0_0_0_0_0_0;
    localparam logic [16:0] W_MEMWR_RDY = 17'b00_0_00_00_0_0_1_0_1_0_0_0_0;
    localparam logic [16:0] W_EXEC      = 17'b10_1_00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] W_RWB       = 17'b00_0_00_00_0_0_0_0_0_0_0_1_0;
    localparam logic [16:0] W_CBZ       = 17'b01_1_00_01_0_1_0_0_0_0_0_0_0;
    localparam logic [16:0] W_JUMP      = 17'b00_0_00_10_1_0_0_0_0_0_0_0_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+2: drive mem_ready, check mid-cycle, advance one clock.
    task automatic step(input string tag, input logic mr, input logic [3:0] exp_st,
                        input logic [16:0] exp_w);
        bus.mem_ready = mr;
        #1;
        check_eq({tag, " state"}, {28'd0, bus.state}, {28'd0, exp_st});
        check_eq({tag, " ctrl"}, {15'd0, ctrl_word}, {15'd0, exp_w});
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.instruction = 11'b10001011000;
        #3;
        // FETCH strobes are suppressed while reset is held even with mem_ready high.
        check_eq("reset state", {28'd0, bus.state}, 32'd0);
        check_eq("reset ctrl", {15'd0, ctrl_word}, {15'd0, W_FETCH_STL});
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // ADD: 4 cycles
        bus.instruction = 11'b10001011000;
        step("add fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("add decode", 1'b1, 4'd1, W_DECODE);
        step("add exec", 1'b1, 4'd6, W_EXEC);
        step("add rwb", 1'b1, 4'd7, W_RWB);
        $display("ADD  done: state %0d", bus.state);

        // LDUR with 2 FETCH stalls and 1 MEMRD stall: 8 cycles
        bus.instruction = 11'b11111000010;
        step("ldur fetch s1", 1'b0, 4'd0, W_FETCH_STL);
        step("ldur fetch s2", 1'b0, 4'd0, W_FETCH_STL);
        step("ldur fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("ldur decode", 1'b1, 4'd1, W_DECODE);
        step("ldur memadr", 1'b1, 4'd2, W_MEMADR);
        step("ldur memrd s", 1'b0, 4'd3, W_MEMRD);
        step("ldur memrd", 1'b1, 4'd3, W_MEMRD);
        step("ldur memwb", 1'b1, 4'd4, W_MEMWB);
        $display("LDUR done: state %0d", bus.state);

        // STUR with 3 MEMWR stalls
        bus.instruction = 11'b11111000000;
        step("stur fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("stur decode", 1'b1, 4'd1, W_DECODE);
        step("stur memadr", 1'b1, 4'd2, W_MEMADR);
        step("stur memwr s1", 1'b0, 4'd5, W_MEMWR_STL);
        step("stur memwr s2", 1'b0, 4'd5, W_MEMWR_STL);
        step("stur memwr s3", 1'b0, 4'd5, W_MEMWR_STL);
        step("stur memwr", 1'b1, 4'd5, W_MEMWR_RDY);
        $display("STUR done: state %0d", bus.state);

        // CBZ then B: 3 cycles each
        bus.instruction = 11'b10110100101;
        step("cbz fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("cbz decode", 1'b1, 4'd1, W_DECODE);
        step("cbz exec", 1'b1, 4'd8, W_CBZ);
        $display("CBZ  done: state %0d", bus.state);
        bus.instruction = 11'b00010111111;
        step("b fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("b decode", 1'b1, 4'd1, W_DECODE);
        step("b jump", 1'b1, 4'd9, W_JUMP);
        $display("B    done: state %0d", bus.state);

        // Prefix-shaped but exact SUB/ORR still decode as R-type
        bus.instruction = 11'b11001011000;
        step("sub fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("sub decode", 1'b1, 4'd1, W_DECODE);
        step("sub exec", 1'b1, 4'd6, W_EXEC);
        step("sub rwb", 1'b1, 4'd7, W_RWB);
        $display("SUB  done: state %0d", bus.state);

        // Unrecognised opcode
        bus.instruction = 11'b00000000000;
        step("ill fetch", 1'b1, 4'd0, W_FETCH_RDY);
`ifdef LEGV8_ILLEGAL_TRAP_EN
        step("ill decode", 1'b1, 4'd1, W_DECODE);
        for (int i = 0; i < 20; i++) begin
            step("ill halt", i[0], 4'd10, 17'd1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ill rst state", {28'd0, bus.state}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
`else
        step("ill decode", 1'b1, 4'd1, W_DECODE_IL);
`endif
        $display("ILL  done: state %0d", bus.state);

        // Async reset mid-MEMWR with mem_ready high
        bus.instruction = 11'b11111000000;
        step("rst fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("rst decode", 1'b1, 4'd1, W_DECODE);
        step("rst memadr", 1'b1, 4'd2, W_MEMADR);
        step("rst memwr s", 1'b0, 4'd5, W_MEMWR_STL);
        bus.mem_ready = 1'b1;
        #1;
        check_eq("rst memwr rdy", {15'd0, ctrl_word}, {15'd0, W_MEMWR_RDY});
        rst_n = 1'b0;
        #1;
        check_eq("rst async state", {28'd0, bus.state}, 32'd0);
        check_eq("rst async ctrl", {15'd0, ctrl_word}, {15'd0, W_FETCH_STL});
        @(posedge clk);
        #2;
        check_eq("rst held state", {28'd0, bus.state}, 32'd0);
        check_eq("rst held memwrite", {31'd0, bus.MemWrite}, 32'd0);
        check_eq("rst held regwrite", {31'd0, bus.RegWrite}, 32'd0);
        rst_n = 1'b1;
        bus.instruction = 11'b10101010000;
        step("post fetch", 1'b1, 4'd0, W_FETCH_RDY);
        step("post decode", 1'b1, 4'd1, W_DECODE);
        step("post exec", 1'b1, 4'd6, W_EXEC);
        $display("RST  done: state %0d", bus.state);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/legv8_mc_control.md
Name: legv8_mc_control

Overview:
- Multi-cycle main control FSM for the LEGv8 datapath.
- Sits directly upstream of the ALU-control decoder: produces the 2-bit ALUOp that decoder consumes, together with all datapath enables and mux selects.
- Decodes the 11-bit opcode field (instruction[31:21]) latched in the IR.
- Stalls on a memory ready handshake.

Parameters:
- None. Opcode width is fixed at 11 and state encoding at 4 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instruction  in  11  IR[31:21] opcode field
- mem_ready  in  1  memory access completes this cycle
- ALUOp  out  2  00 add, 01 pass-B (CBZ), 10 R-type funct decode
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext offset<<2
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back source: 1 = MDR
- RegWrite  out  1  register-file write enable
- illegal  out  1  unrecognised opcode indication
- state  out  4  current state, for debug

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, CBZ 8, JUMP 9, HALT 10 (HALT exists only with the macro).
- Reset: async to FETCH. While rst_n = 0, PCWrite, PCWriteCond, IRWrite, MemWrite and RegWrite are forced 0.
- Outputs are combinational from state (Moore), except the mem_ready gating below. Any output not listed for a state is 0.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite = PCWrite = mem_ready. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target computed into ALUOut). Next state by opcode:
  - LDUR 11111000010 or STUR 11111000000 -> MEMADR
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC
  - instruction[10:3] = 10110100 (CBZ) -> CBZ
  - instruction[10:5] = 000101 (B) -> JUMP
  - otherwise -> illegal handling
  - Exact 11-bit matches take priority over prefix matches.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD for LDUR, MEMWR for STUR.
- MEMRD: MemRead = 1, IorD = 1. Holds while mem_ready = 0; goes to MEMWB on mem_ready = 1.
- MEMWB: RegWrite = 1, MemtoReg = 1 -> FETCH.
- MEMWR: IorD = 1, MemWrite = mem_ready. Holds until mem_ready = 1, then -> FETCH. MemWrite is asserted exactly once.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> RWB.
- RWB: RegWrite = 1, MemtoReg = 0 -> FETCH.
- CBZ: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01 -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10 -> FETCH.
- Instruction latency with mem_ready tied high:
  - R-type: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ: 3 cycles
  - B: 3 cycles
- Each stalled memory cycle adds 1.
- instruction is sampled only in DECODE and MEMADR; IR stability elsewhere is not required.
- Unreachable state encodings -> FETCH.

Optional Feature:
- Macro: LEGV8_ILLEGAL_TRAP_EN.
- Defined:
  - Unrecognised opcode in DECODE -> HALT.
  - HALT: all enables 0, illegal = 1, self-loop until reset.
- Undefined:
  - Unrecognised opcode in DECODE -> FETCH (executes as a NOP).
  - illegal = 1 for that single DECODE cycle only.
  - HALT state is absent.

Test Plan:
- ADD opcode 10001011000, mem_ready = 1 -> state 0,1,6,7,0. ALUOp = 10 in EXEC. RegWrite = 1, MemtoReg = 0 in RWB only. 4 cycles total.
- LDUR, mem_ready low 2 cycles in FETCH and low 1 cycle in MEMRD -> FETCH held 3 cycles with IRWrite = PCWrite = 0 until the ready cycle. MEMRD held 2 cycles. MEMWB RegWrite = 1, MemtoReg = 1. 8 cycles total.
- STUR with mem_ready low 3 cycles in MEMWR -> MemWrite = 0 for 3 cycles, then 1 for exactly one cycle, then FETCH. ALUOp = 00 in MEMADR.
- CBZ 10110100xxx then B 000101xxxxx -> CBZ state: ALUOp = 01, PCWriteCond = 1, PCSource = 01. JUMP state: PCWrite = 1, PCSource = 10. 3 cycles each.
- Opcode 00000000000 -> without the macro: illegal = 1 for one cycle, then FETCH. With LEGV8_ILLEGAL_TRAP_EN: state = 10, illegal held 1, all enables 0 for 20 cycles, then rst_n pulse -> FETCH.
- rst_n asserted low mid-MEMWR while mem_ready = 1 -> state = 0 immediately (async). MemWrite = 0 and RegWrite = 0 while rst_n = 0. After release, normal FETCH begins.
